// File: rtl/cska_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-skip adder.
// Holds the per-stage control record and the sizing functions used by the top.
// No logic lives here.
package cska_pkg;

    // Skip groups narrower than this have no propagate chain worth skipping.
    localparam int MIN_BLOCK = 2;

    // Control part of one pipeline stage register.
    typedef struct packed {
        logic valid;         // stage holds a real beat, not a bubble
        logic carry;         // carry into the next group; raw carry-out at the last stage
        logic msb_carry_in;  // carry into the MSB, only meaningful at the last stage
    } stage_ctl_t;

    // Number of skip groups, which is also the pipeline depth.
    function automatic int ng(input int width, input int block);
        return width / block;
    endfunction

    // Leftover operand bits shrink by one group per stage, so all stages share
    // one triangular store. Stage j keeps (ngrp-1-j)*block bits starting here.
    function automatic int rem_off(input int j, input int ngrp, input int block);
        return block * (j * (ngrp - 1) - (j * (j - 1)) / 2);
    endfunction

    // Total width of the triangular store (kept at least one bit wide).
    function automatic int rem_width(input int ngrp, input int block);
        return (ngrp > 1) ? (block * ngrp * (ngrp - 1)) / 2 : 1;
    endfunction

endpackage

// File: rtl/cska_pipe_if.sv
// Operand and result streams of the pipelined adder, both valid/ready.
// master: the client that supplies operands and consumes results.
// slave: the adder itself.
interface cska_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cska_group.sv
// One BLOCK-bit skip group: ripple sum plus propagate-controlled carry bypass.
// Latency: purely combinational, no state.
// Backpressure: none; the enclosing pipeline stage decides when results are captured.
module cska_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [BLOCK:0]   c;
    logic [BLOCK-1:0] p;
    logic             prop;

    // Bit-serial ripple through the group, recording every internal carry.
    always_comb begin
        c    = '0;
        sum  = '0;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i]   = p[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (p[i] & c[i]);
        end
    end

    // When every bit propagates the ripple result equals cin anyway, so taking
    // cin directly is exact (no false carry) and cuts the ripple off the path.
    assign prop = &p;
    assign cout = prop ? cin : c[BLOCK];
    assign cmsb = c[BLOCK-1];

endmodule

// File: rtl/cska_pipe.sv
// Pipelined carry-skip adder/subtractor, one skip group resolved per stage.
// Latency: WIDTH/BLOCK edges from accept to out_valid, one beat per cycle.
// Backpressure: whole pipe advances only when the output is empty or taken; in_ready mirrors that.
module cska_pipe
    import cska_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic       clk,
    input  logic       rst,
    cska_pipe_if.slave bus
);

    localparam int NG    = ng(WIDTH, BLOCK);
    localparam int REM_W = rem_width(NG, BLOCK);

    if (((WIDTH % BLOCK) != 0) || (BLOCK < MIN_BLOCK)) begin : g_bad_params
        $error("cska_pipe: WIDTH must be a multiple of BLOCK and BLOCK must be >= %0d", MIN_BLOCK);
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Group-level combinational signals, index = group number.
    logic [BLOCK-1:0] g_a   [NG];
    logic [BLOCK-1:0] g_b   [NG];
    logic [BLOCK-1:0] g_sum [NG];
    logic             g_cin [NG];
    logic             g_cout[NG];
    logic             g_cmsb[NG];

    // Stage register j sits after group j; register NG-1 drives the outputs.
    stage_ctl_t       ctl_q  [NG];
    stage_ctl_t       nxt_ctl[NG];
    logic [WIDTH-1:0] sum_q  [NG];
    logic [WIDTH-1:0] nxt_sum[NG];

    // Operand slices not yet consumed, packed triangularly across stages.
    logic [REM_W-1:0] a_rem_q;
    logic [REM_W-1:0] b_rem_q;
    logic [REM_W-1:0] nxt_a_rem;
    logic [REM_W-1:0] nxt_b_rem;

    // Subtraction folds into addition of the inverted operand with inverted borrow.
    assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign c0    = bus.in_cin ^ bus.in_sub;

    // Every stage moves in lockstep, so one advance term covers the whole pipe.
    assign adv          = !ctl_q[NG-1].valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar j = 0; j < NG; j++) begin : g_stage
        // Leftover operand width once group j has been consumed.
        localparam int RW = WIDTH - (j + 1) * BLOCK;

        if (j == 0) begin : g_src
            assign g_a[j]   = bus.in_a[BLOCK-1:0];
            assign g_b[j]   = b_eff[BLOCK-1:0];
            assign g_cin[j] = c0;
            assign nxt_sum[j] = WIDTH'(g_sum[j]);
            assign nxt_ctl[j] = stage_ctl_t'{
                valid:        bus.in_valid,
                carry:        g_cout[j],
                msb_carry_in: (j == NG - 1) ? g_cmsb[j] : 1'b0
            };
            if (j < NG - 1) begin : g_rem
                assign nxt_a_rem[rem_off(j, NG, BLOCK) +: RW] = bus.in_a[WIDTH-1:BLOCK];
                assign nxt_b_rem[rem_off(j, NG, BLOCK) +: RW] = b_eff[WIDTH-1:BLOCK];
            end
        end else begin : g_src
            assign g_a[j]   = a_rem_q[rem_off(j - 1, NG, BLOCK) +: BLOCK];
            assign g_b[j]   = b_rem_q[rem_off(j - 1, NG, BLOCK) +: BLOCK];
            assign g_cin[j] = ctl_q[j-1].carry;
            // Upper sum bits are still zero here, so OR-ing in the new slice is exact.
            assign nxt_sum[j] = sum_q[j-1] | (WIDTH'(g_sum[j]) << (j * BLOCK));
            assign nxt_ctl[j] = stage_ctl_t'{
                valid:        ctl_q[j-1].valid,
                carry:        g_cout[j],
                msb_carry_in: (j == NG - 1) ? g_cmsb[j] : 1'b0
            };
            if (j < NG - 1) begin : g_rem
                assign nxt_a_rem[rem_off(j, NG, BLOCK) +: RW] =
                    a_rem_q[rem_off(j - 1, NG, BLOCK) + BLOCK +: RW];
                assign nxt_b_rem[rem_off(j, NG, BLOCK) +: RW] =
                    b_rem_q[rem_off(j - 1, NG, BLOCK) + BLOCK +: RW];
            end
        end

        cska_group #(
            .BLOCK (BLOCK)
        ) u_group (
            .a    (g_a[j]),
            .b    (g_b[j]),
            .cin  (g_cin[j]),
            .sum  (g_sum[j]),
            .cout (g_cout[j]),
            .cmsb (g_cmsb[j])
        );
    end

    if (NG == 1) begin : g_no_rem
        assign nxt_a_rem = '0;
        assign nxt_b_rem = '0;
    end

    // Shift all stages together on advance; reset clears everything, stalled or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NG; j++) begin
                ctl_q[j] <= '0;
                sum_q[j] <= '0;
            end
            a_rem_q <= '0;
            b_rem_q <= '0;
        end else if (adv) begin
            for (int j = 0; j < NG; j++) begin
                ctl_q[j] <= nxt_ctl[j];
                sum_q[j] <= nxt_sum[j];
            end
            a_rem_q <= nxt_a_rem;
            b_rem_q <= nxt_b_rem;
        end
    end

    assign bus.out_valid = ctl_q[NG-1].valid;
    assign bus.out_sum   = sum_q[NG-1];
    assign bus.out_cout  = ctl_q[NG-1].carry;
    assign bus.out_ovf   = ctl_q[NG-1].msb_carry_in ^ ctl_q[NG-1].carry;

endmodule

// File: tb/tb_cska_pipe.sv
// Directed bench for cska_pipe at WIDTH=16, BLOCK=4 (four-stage pipe).
// Drives at posedge+1, samples after settling; all waits are cycle-bounded.
module tb_cska_pipe;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    cska_pipe_if #(.WIDTH(16)) bus ();

    cska_pipe #(
        .WIDTH (16),
        .BLOCK (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} via plain wide addition and sign rules.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] r;
        logic        ov;
        be = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + 17'(cin ^ sub);
        ov = (a[15] == be[15]) && (r[15] != a[15]);
        return {ov, r};
    endfunction

    // One isolated operation: checks latency and all result fields.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
        int edges;
        bus.out_ready = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'd4);
        chk({tag, "_sum"}, 32'(bus.out_sum), 32'(e_sum));
        chk({tag, "_cout"}, 32'(bus.out_cout), 32'(e_cout));
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(e_ovf));
        @(posedge clk); #1;
    endtask

    logic [15:0] ra [8];
    logic [15:0] rb [8];
    logic        rc [8];
    logic        rs [8];
    logic [17:0] expq [$];
    logic [17:0] e;
    logic [15:0] held;
    logic [15:0] av;
    logic        vin [16];
    logic        stall;
    logic        acc;
    int          sent;
    int          got;
    int          stale;

    initial begin
        n_run         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_sum", 32'(bus.out_sum), 32'd0);
        chk("reset_out_cout", 32'(bus.out_cout), 32'd0);
        chk("reset_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed arithmetic
        run_op("skip_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_plain",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("sub_bin",    16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
        run_op("add_wrap",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Back-to-back stream with a 3-cycle output stall
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rc[i] = 1'($urandom);
            rs[i] = 1'($urandom);
        end
        sent = 0;
        got  = 0;
        held = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            stall         = (cyc >= 5) && (cyc <= 7);
            bus.out_ready = !stall;
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.in_a     = ra[sent];
                bus.in_b     = rb[sent];
                bus.in_cin   = rc[sent];
                bus.in_sub   = rs[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", 32'(bus.in_ready), 32'(!stall));
            if (stall) begin
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                if (cyc == 5) held = bus.out_sum;
                else chk("stall_sum_stable", 32'(bus.out_sum), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_pending", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("stream_result", 32'({bus.out_ovf, bus.out_cout, bus.out_sum}), 32'(e));
                end
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                expq.push_back(model(ra[sent], rb[sent], rc[sent], rs[sent]));
                sent++;
            end
        end
        chk("stream_delivered", 32'(got), 32'd8);
        chk("stream_accepted", 32'(sent), 32'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Bubbles: every other cycle carries a beat
        for (int t = 0; t < 14; t++) begin
            vin[t]       = (t < 8) && ((t % 2) == 0);
            bus.in_valid = vin[t];
            bus.in_a     = 16'(t) * 16'h1111;
            bus.in_b     = 16'h0101;
            bus.in_cin   = 1'b0;
            bus.in_sub   = 1'b0;
            #1;
            chk("bubble_out_valid", 32'(bus.out_valid), 32'((t >= 4) ? vin[t-4] : 1'b0));
            if (t >= 4 && vin[t-4]) begin
                av = 16'(t - 4) * 16'h1111;
                e  = model(av, 16'h0101, 1'b0, 1'b0);
                chk("bubble_result", 32'({bus.out_ovf, bus.out_cout, bus.out_sum}), 32'(e));
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        // Reset with beats in flight and the output stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 16'(i + 1) * 16'h1000;
            bus.in_b     = 16'h0001;
            bus.in_cin   = 1'b0;
            bus.in_sub   = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h0F0F;
        bus.in_b     = 16'h0F0F;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) stale++;
            @(posedge clk); #1;
        end
        chk("rst_no_stale", 32'(stale), 32'd0);
        run_op("post_rst", 16'h0F0F, 16'h0101, 1'b1, 1'b0, 16'h1011, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
